// File: rtl/entrada_dados_if.sv
// Handshake bundle between the processor/user-panel side and the IN-instruction input stage.
// Signal names follow the processor's I/O wiring so the top-level netlist reads unchanged.
interface entrada_dados_if;
  logic [1:0]  IO;
  logic [10:0] Switches;
  logic        Botao;
  logic [31:0] Dado;
  logic        Halt;
  logic        Pronto;

  modport master (
    output IO,
    output Switches,
    output Botao,
    input  Dado,
    input  Halt,
    input  Pronto
  );

  modport slave (
    input  IO,
    input  Switches,
    input  Botao,
    output Dado,
    output Halt,
    output Pronto
  );
endinterface

// File: rtl/entrada_dados.sv
// IN-instruction input stage: stalls the processor, debounces the confirm key and captures
// the sign+magnitude switches as a 32-bit two's-complement word.
module entrada_dados #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  entrada_dados_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PRESS = 3'd1,
    DEB_PRESS  = 3'd2,
    CAPTURE    = 3'd3,
    WAIT_REL   = 3'd4,
    DEB_REL    = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   sync1_q;
  logic                   sync2_q;
  logic [31:0]            dado_q;

  logic                   pressed_s;
  logic                   io_req_s;
  logic [31:0]            dado_d;
  logic                   halt_s;
  logic                   pronto_s;

  // A sign bit with zero magnitude naturally folds to 0 under negation.
  function automatic logic [31:0] to_twos(input logic [10:0] sw);
    logic [31:0] mag;
    mag = {22'd0, sw[9:0]};
    return sw[10] ? (~mag + 32'd1) : mag;
  endfunction

  assign pressed_s = ~sync2_q;
  assign io_req_s  = (bus.IO == 2'b10);
  assign dado_d    = to_twos(bus.Switches);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dado_q  <= 32'd0;
    end else begin
      sync1_q <= bus.Botao;
      sync2_q <= sync1_q;
      case (state_q)
        IDLE: begin
          if (io_req_s) begin
            state_q <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (pressed_s) begin
            state_q <= DEB_PRESS;
            cnt_q   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!pressed_s) begin
            state_q <= WAIT_PRESS;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        CAPTURE: begin
          dado_q  <= dado_d;
          state_q <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!pressed_s) begin
            state_q <= DEB_REL;
            cnt_q   <= '0;
          end
        end
        DEB_REL: begin
          if (pressed_s) begin
            state_q <= WAIT_REL;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Halt must drop in CAPTURE so the IN instruction can retire as the value lands.
  always_comb begin
    halt_s   = 1'b0;
    pronto_s = 1'b0;
    if (Reset) begin
      halt_s   = 1'b0;
      pronto_s = 1'b0;
    end else begin
      case (state_q)
        WAIT_PRESS, DEB_PRESS: halt_s = 1'b1;
        IDLE, WAIT_REL, DEB_REL: halt_s = io_req_s;
        CAPTURE: begin
          halt_s   = 1'b0;
          pronto_s = 1'b1;
        end
        default: halt_s = 1'b0;
      endcase
    end
  end

  assign bus.Dado   = dado_q;
  assign bus.Halt   = halt_s;
  assign bus.Pronto = pronto_s;

endmodule

// File: tb/tb_entrada_dados.sv
// Directed bench for entrada_dados with a 4-cycle debounce; inputs change and outputs are
// observed on the falling clock edge.
module tb_entrada_dados;
  logic CLK = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  entrada_dados_if bus_if ();

  entrada_dados #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(negedge CLK);
  endtask

  // Clean press with IO held until Pronto, then release long enough to return to IDLE.
  task automatic do_capture(input logic [10:0] sw, output int cnt);
    bus_if.IO = 2'b10;
    bus_if.Switches = sw;
    cyc(); cyc();
    bus_if.Botao = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus_if.Pronto === 1'b1) begin
        cnt++;
        bus_if.IO = 2'b00;
      end
    end
    bus_if.Botao = 1'b1;
    repeat (9) cyc();
  endtask

  task automatic test_reset();
    int pr;
    Reset = 1'b1;
    bus_if.IO = 2'b00;
    bus_if.Switches = 11'd0;
    bus_if.Botao = 1'b1;
    cyc(); cyc();
    checks++; if (bus_if.Halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", bus_if.Halt); end
    checks++; if (bus_if.Pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got=%b exp=0", bus_if.Pronto); end
    bus_if.IO = 2'b10;
    #1;
    checks++; if (bus_if.Halt !== 1'b0) begin errors++; $display("FAIL reset_halt_forced got=%b exp=0", bus_if.Halt); end
    cyc();
    bus_if.IO = 2'b00;
    Reset = 1'b0;
    cyc();
    checks++; if (bus_if.Dado !== 32'd0) begin errors++; $display("FAIL reset_dado got=%h exp=00000000", bus_if.Dado); end
    checks++; if (bus_if.Halt !== 1'b0) begin errors++; $display("FAIL idle_halt got=%b exp=0", bus_if.Halt); end
    pr = 0;
    for (int i = 0; i < 12; i++) begin
      bus_if.Botao = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc();
      if (bus_if.Pronto === 1'b1) pr++;
    end
    bus_if.Botao = 1'b0;
    repeat (8) begin cyc(); if (bus_if.Pronto === 1'b1) pr++; end
    bus_if.Botao = 1'b1;
    repeat (4) begin cyc(); if (bus_if.Pronto === 1'b1) pr++; end
    checks++; if (pr !== 0) begin errors++; $display("FAIL idle_toggle_pronto got=%0d exp=0", pr); end
  endtask

  task automatic test_positive();
    int first;
    int cnt;
    int halt_bad;
    bus_if.IO = 2'b10;
    bus_if.Switches = 11'h2AA;
    cyc(); cyc();
    checks++; if (bus_if.Halt !== 1'b1) begin errors++; $display("FAIL wait_halt got=%b exp=1", bus_if.Halt); end
    bus_if.Botao = 1'b0;
    first = -1; cnt = 0; halt_bad = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 3) bus_if.Switches = 11'h07B;
      if (bus_if.Pronto === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        bus_if.IO = 2'b00;
      end else if (first < 0 && bus_if.Halt !== 1'b1) begin
        halt_bad++;
      end
    end
    checks++; if (first !== 6) begin errors++; $display("FAIL pronto_latency got=%0d exp=6", first); end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL pronto_once got=%0d exp=1", cnt); end
    checks++; if (halt_bad !== 0) begin errors++; $display("FAIL halt_until_capture got=%0d exp=0", halt_bad); end
    checks++; if (bus_if.Dado !== 32'd123) begin errors++; $display("FAIL dado_123 got=%h exp=0000007b", bus_if.Dado); end
    checks++; if (bus_if.Halt !== 1'b0) begin errors++; $display("FAIL halt_after_retire got=%b exp=0", bus_if.Halt); end
    bus_if.Botao = 1'b1;
    repeat (9) cyc();
  endtask

  task automatic test_values();
    int cnt;
    do_capture({1'b1, 10'd512}, cnt);
    checks++; if (cnt !== 1 || bus_if.Dado !== 32'hFFFFFE00) begin errors++; $display("FAIL neg512 got=%h cnt=%0d exp=fffffe00 cnt=1", bus_if.Dado, cnt); end
    do_capture({1'b1, 10'd0}, cnt);
    checks++; if (cnt !== 1 || bus_if.Dado !== 32'd0) begin errors++; $display("FAIL neg_zero got=%h cnt=%0d exp=00000000 cnt=1", bus_if.Dado, cnt); end
    do_capture({1'b0, 10'd1023}, cnt);
    checks++; if (cnt !== 1 || bus_if.Dado !== 32'd1023) begin errors++; $display("FAIL pos1023 got=%h cnt=%0d exp=000003ff cnt=1", bus_if.Dado, cnt); end
    do_capture({1'b1, 10'd1023}, cnt);
    checks++; if (cnt !== 1 || bus_if.Dado !== 32'hFFFFFC01) begin errors++; $display("FAIL neg1023 got=%h cnt=%0d exp=fffffc01 cnt=1", bus_if.Dado, cnt); end
    bus_if.Switches = 11'h155;
    repeat (3) cyc();
    checks++; if (bus_if.Dado !== 32'hFFFFFC01) begin errors++; $display("FAIL dado_hold got=%h exp=fffffc01", bus_if.Dado); end
  endtask

  task automatic test_back_to_back();
    int pr_b;
    int pr_s;
    int halt_bad;
    bus_if.IO = 2'b10;
    bus_if.Switches = 11'd10;
    cyc(); cyc();
    pr_b = 0;
    for (int i = 0; i < 6; i++) begin
      bus_if.Botao = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc();
      if (bus_if.Pronto === 1'b1) pr_b++;
    end
    bus_if.Botao = 1'b0;
    pr_s = 0;
    repeat (12) begin cyc(); if (bus_if.Pronto === 1'b1) pr_s++; end
    checks++; if (pr_b !== 0) begin errors++; $display("FAIL bounce_pronto got=%0d exp=0", pr_b); end
    checks++; if (pr_s !== 1 || bus_if.Dado !== 32'd10) begin errors++; $display("FAIL bounce_capture got=%h cnt=%0d exp=0000000a cnt=1", bus_if.Dado, pr_s); end
    bus_if.Switches = 11'd20;
    halt_bad = 0; pr_s = 0;
    repeat (8) begin
      cyc();
      if (bus_if.Halt !== 1'b1) halt_bad++;
      if (bus_if.Pronto === 1'b1) pr_s++;
    end
    bus_if.Botao = 1'b1;
    repeat (10) begin
      cyc();
      if (bus_if.Halt !== 1'b1) halt_bad++;
      if (bus_if.Pronto === 1'b1) pr_s++;
    end
    checks++; if (halt_bad !== 0 || pr_s !== 0) begin errors++; $display("FAIL held_key_blocks halt_bad=%0d pronto=%0d exp=0,0", halt_bad, pr_s); end
    bus_if.Botao = 1'b0;
    pr_s = 0;
    repeat (12) begin
      cyc();
      if (bus_if.Pronto === 1'b1) begin pr_s++; bus_if.IO = 2'b00; end
    end
    checks++; if (pr_s !== 1 || bus_if.Dado !== 32'd20) begin errors++; $display("FAIL second_request got=%h cnt=%0d exp=00000014 cnt=1", bus_if.Dado, pr_s); end
    bus_if.Botao = 1'b1;
    repeat (9) cyc();
  endtask

  task automatic test_reset_mid();
    int halt_bad;
    int pr;
    bus_if.IO = 2'b10;
    bus_if.Switches = 11'h123;
    cyc(); cyc();
    bus_if.Botao = 1'b0;
    repeat (4) cyc();
    Reset = 1'b1;
    cyc();
    checks++; if (bus_if.Halt !== 1'b0 || bus_if.Pronto !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs halt=%b pronto=%b exp=0,0", bus_if.Halt, bus_if.Pronto); end
    Reset = 1'b0;
    bus_if.IO = 2'b00;
    halt_bad = 0; pr = 0;
    repeat (8) begin
      cyc();
      if (bus_if.Halt !== 1'b0) halt_bad++;
      if (bus_if.Pronto === 1'b1) pr++;
    end
    checks++; if (bus_if.Dado !== 32'd0) begin errors++; $display("FAIL mid_reset_dado got=%h exp=00000000", bus_if.Dado); end
    bus_if.IO = 2'b01;
    bus_if.Botao = 1'b1;
    repeat (9) begin cyc(); if (bus_if.Halt !== 1'b0) halt_bad++; if (bus_if.Pronto === 1'b1) pr++; end
    bus_if.Botao = 1'b0;
    repeat (10) begin cyc(); if (bus_if.Halt !== 1'b0) halt_bad++; if (bus_if.Pronto === 1'b1) pr++; end
    checks++; if (halt_bad !== 0 || pr !== 0 || bus_if.Dado !== 32'd0) begin errors++; $display("FAIL io_ignored halt_bad=%0d pronto=%0d dado=%h exp=0,0,0", halt_bad, pr, bus_if.Dado); end
    bus_if.IO = 2'b10;
    #1;
    checks++; if (bus_if.Halt !== 1'b1) begin errors++; $display("FAIL idle_halt_follows_io got=%b exp=1", bus_if.Halt); end
    bus_if.IO = 2'b00;
    #1;
    checks++; if (bus_if.Halt !== 1'b0) begin errors++; $display("FAIL idle_halt_drops got=%b exp=0", bus_if.Halt); end
    bus_if.Botao = 1'b1;
    repeat (4) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_positive();
    test_values();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
